// File: rtl/cg_enable_ctrl.sv
// Clock-gate enable controller: drops gate_en after IDLE_THRESH idle cycles and
// restores it on demand, raising ready and pulsing wake_ack after WAKE_DLY cycles.
module cg_enable_ctrl #(
  parameter int IDLE_THRESH = 8,
  parameter int WAKE_DLY    = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             busy,
  input  logic             wake_req,
  input  logic             force_on,
  input  logic             clr_cnt,
  output logic             gate_en,
  output logic             ready,
  output logic             wake_ack,
  output logic [CNT_W-1:0] gated_cycles,
  output logic [1:0]       state_dbg
);

  localparam int IW = $clog2(IDLE_THRESH + 1);
  localparam int WW = $clog2(WAKE_DLY + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_THRESH - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_DLY - 1);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    OFF  = 2'd1,
    WAKE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    idle_cnt, idle_cnt_nxt;
  logic [WW-1:0]    wake_cnt, wake_cnt_nxt;
  logic             wake_ack_nxt;
  logic [CNT_W-1:0] gated_cycles_nxt;
  logic             idle;

  assign idle      = !busy && !wake_req && !force_on;
  assign state_dbg = state;

  // Wake handshake: gate_en rises one edge after the wake condition; ready
  // rises and wake_ack pulses together WAKE_DLY edges later. Inputs are
  // ignored while waking, so a wake always completes.
  always_comb begin
    state_nxt        = state;
    idle_cnt_nxt     = idle_cnt;
    wake_cnt_nxt     = wake_cnt;
    wake_ack_nxt     = 1'b0;
    gated_cycles_nxt = gated_cycles;
    case (state)
      RUN: begin
        if (idle) begin
          if (idle_cnt == IDLE_LAST) begin
            state_nxt    = OFF;
            idle_cnt_nxt = '0;
          end else begin
            idle_cnt_nxt = idle_cnt + 1'b1;
          end
        end else begin
          idle_cnt_nxt = '0;
        end
      end
      OFF: begin
        if (!idle) begin
          state_nxt    = WAKE;
          wake_cnt_nxt = '0;
        end
      end
      WAKE: begin
        if (wake_cnt == WAKE_LAST) begin
          state_nxt    = RUN;
          idle_cnt_nxt = '0;
          wake_ack_nxt = 1'b1;
        end else begin
          wake_cnt_nxt = wake_cnt + 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
    if (clr_cnt) begin
      gated_cycles_nxt = '0;
    end else if (state == OFF && gated_cycles != '1) begin
      gated_cycles_nxt = gated_cycles + 1'b1;
    end
  end

  // gate_en/ready are flops fed from the next state so the gating cell only
  // ever sees a clean edge-aligned transition.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      idle_cnt     <= '0;
      wake_cnt     <= '0;
      gate_en      <= 1'b1;
      ready        <= 1'b1;
      wake_ack     <= 1'b0;
      gated_cycles <= '0;
    end else begin
      state        <= state_nxt;
      idle_cnt     <= idle_cnt_nxt;
      wake_cnt     <= wake_cnt_nxt;
      gate_en      <= (state_nxt != OFF);
      ready        <= (state_nxt == RUN);
      wake_ack     <= wake_ack_nxt;
      gated_cycles <= gated_cycles_nxt;
    end
  end

endmodule

// File: tb/tb_cg_enable_ctrl.sv
// Bench for cg_enable_ctrl: directed scenarios plus random traffic, compared
// against a behavioural model of idle streaks, gated periods and wake countdowns.
module tb_cg_enable_ctrl;

  localparam int IDLE_THRESH = 4;
  localparam int WAKE_DLY    = 2;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b1;
  logic        busy = 1'b0, wake_req = 1'b0, force_on = 1'b0, clr_cnt = 1'b0;
  logic        gate_en_a, ready_a, wake_ack_a;
  logic        gate_en_b, ready_b, wake_ack_b;
  logic [15:0] gc_a;
  logic [2:0]  gc_b;
  logic [1:0]  state_dbg_a, state_dbg_b;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  bit m_off;
  int m_wake_left;
  int m_streak;
  bit m_ack;
  int m_gc16, m_gc3;

  cg_enable_ctrl #(.IDLE_THRESH(IDLE_THRESH), .WAKE_DLY(WAKE_DLY), .CNT_W(16)) dut_a (
    .clk_in(clk_in), .rst_n(rst_n), .busy(busy), .wake_req(wake_req),
    .force_on(force_on), .clr_cnt(clr_cnt), .gate_en(gate_en_a), .ready(ready_a),
    .wake_ack(wake_ack_a), .gated_cycles(gc_a), .state_dbg(state_dbg_a)
  );

  cg_enable_ctrl #(.IDLE_THRESH(IDLE_THRESH), .WAKE_DLY(WAKE_DLY), .CNT_W(3)) dut_b (
    .clk_in(clk_in), .rst_n(rst_n), .busy(busy), .wake_req(wake_req),
    .force_on(force_on), .clr_cnt(clr_cnt), .gate_en(gate_en_b), .ready(ready_b),
    .wake_ack(wake_ack_b), .gated_cycles(gc_b), .state_dbg(state_dbg_b)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_off = 0; m_wake_left = 0; m_streak = 0; m_ack = 0; m_gc16 = 0; m_gc3 = 0;
  endtask

  // One rising edge of the reference behaviour.
  task automatic model_edge(input bit idle, input bit clr);
    bit was_off;
    was_off = m_off;
    m_ack = 0;
    if (clr) begin
      m_gc16 = 0; m_gc3 = 0;
    end else if (was_off) begin
      if (m_gc16 < 65535) m_gc16++;
      if (m_gc3 < 7) m_gc3++;
    end
    if (m_wake_left > 0) begin
      m_wake_left--;
      if (m_wake_left == 0) begin
        m_ack = 1; m_streak = 0;
      end
    end else if (m_off) begin
      if (!idle) begin
        m_off = 0; m_wake_left = WAKE_DLY;
      end
    end else if (idle) begin
      m_streak++;
      if (m_streak == IDLE_THRESH) begin
        m_off = 1; m_streak = 0;
      end
    end else begin
      m_streak = 0;
    end
  endtask

  task automatic check_all(input string tag);
    bit exp_gate, exp_ready;
    exp_gate  = !m_off;
    exp_ready = !m_off && (m_wake_left == 0);
    check({tag, "_gate_a"},  32'(gate_en_a),  32'(exp_gate));
    check({tag, "_ready_a"}, 32'(ready_a),    32'(exp_ready));
    check({tag, "_ack_a"},   32'(wake_ack_a), 32'(m_ack));
    check({tag, "_gc_a"},    32'(gc_a),       32'(m_gc16));
    check({tag, "_gate_b"},  32'(gate_en_b),  32'(exp_gate));
    check({tag, "_ready_b"}, 32'(ready_b),    32'(exp_ready));
    check({tag, "_ack_b"},   32'(wake_ack_b), 32'(m_ack));
    check({tag, "_gc_b"},    32'(gc_b),       32'(m_gc3));
  endtask

  // Called at a falling edge; drives inputs, runs one rising edge, checks at the next falling edge.
  task automatic step(input string tag, input logic b, input logic w, input logic f, input logic c);
    busy = b; wake_req = w; force_on = f; clr_cnt = c;
    @(posedge clk_in);
    model_edge(!b && !w && !f, c);
    @(negedge clk_in);
    check_all(tag);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all({tag, "_now"});
    repeat (2) begin
      @(negedge clk_in);
      check_all({tag, "_hold"});
    end
    rst_n = 1'b1;
  endtask

  int ack_cnt;
  int gc_before;
  int r;

  initial begin
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("reset");
    @(negedge clk_in);
    rst_n = 1'b1;

    // idle from reset release gates after the 4th edge
    repeat (3) step("idle", 0, 0, 0, 0);
    check("req33_gate_before", 32'(gate_en_a), 32'd1);
    step("idle", 0, 0, 0, 0);
    check("req33_gate_off", 32'(gate_en_a), 32'd0);
    step("off", 0, 0, 0, 0);
    check("req33_gc_first", 32'(gc_a), 32'd1);

    step("wake", 0, 1, 0, 0);
    repeat (2) step("waking", 0, 0, 0, 0);

    // a single busy sample restarts the idle count
    repeat (3) step("req34_idle", 0, 0, 0, 0);
    step("req34_busy", 1, 0, 0, 0);
    repeat (3) begin
      step("req34_idle2", 0, 0, 0, 0);
      check("req34_gate", 32'(gate_en_a), 32'd1);
    end

    step("to_off", 0, 0, 0, 0);
    step("off", 0, 0, 0, 0);
    step("req35_k", 0, 1, 0, 0);
    check("req35_gate_k", 32'(gate_en_a), 32'd1);
    check("req35_ready_k", 32'(ready_a), 32'd0);
    step("req35_k1", 0, 0, 0, 0);
    check("req35_ack_k1", 32'(wake_ack_a), 32'd0);
    step("req35_k2", 0, 0, 0, 0);
    check("req35_ready_k2", 32'(ready_a), 32'd1);
    check("req35_ack_k2", 32'(wake_ack_a), 32'd1);
    step("req35_k3", 0, 0, 0, 0);
    check("req35_ack_k3", 32'(wake_ack_a), 32'd0);

    gc_before = m_gc16;
    repeat (20) begin
      step("req36_force", 0, 0, 1, 0);
      check("req36_gate", 32'(gate_en_a), 32'd1);
    end
    check("req36_gc", 32'(gc_a), 32'(gc_before));

    repeat (4) step("to_off", 0, 0, 0, 0);
    repeat (10) step("req37_off", 0, 0, 0, 0);
    check("req37_sat", 32'(gc_b), 32'd7);
    step("req37_clr", 0, 0, 0, 1);
    check("req37_clr_b", 32'(gc_b), 32'd0);
    check("req37_clr_a", 32'(gc_a), 32'd0);

    ack_cnt = 0;
    repeat (6) begin
      step("req27_all", 1, 1, 1, 0);
      ack_cnt += int'(wake_ack_a);
    end
    check("req27_acks", 32'(ack_cnt), 32'd1);

    repeat (4) step("to_off", 0, 0, 0, 0);
    step("req38_wake", 1, 0, 0, 0);
    apply_reset("req38_rst");
    repeat (4) step("after_rst", 0, 0, 0, 0);
    step("off", 0, 0, 0, 0);
    apply_reset("rst_in_off");

    repeat (600) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 249) == 0) begin
        apply_reset("rand_rst");
      end else begin
        step("rand", r < 6 || r == 11, (r >= 6 && r < 9) || r == 11,
             (r >= 9 && r < 11) || r == 11, $urandom_range(0, 49) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cg_enable_ctrl.md
CG_ENABLE_CTRL -- requirements
Module: cg_enable_ctrl

Upstream controller that generates the enable for the latch-based clock gating cell. It gates the clock after a programmable idle period and ungates on demand, with a handshake.

Interface
REQ-001 SHALL provide parameter IDLE_THRESH, default 8: number of consecutive idle cycles before gating; legal range >= 1.
REQ-002 SHALL provide parameter WAKE_DLY, default 2: cycles the gated clock runs before ready is asserted; legal range >= 1.
REQ-003 SHALL provide parameter CNT_W, default 16: width of gated_cycles.
REQ-004 SHALL provide port clk_in, input, 1: free-running ungated clock; the only clock.
REQ-005 SHALL provide port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL provide port busy, input, 1: downstream activity; a high sample keeps or restores the clock.
REQ-007 SHALL provide port wake_req, input, 1: explicit request to ungate.
REQ-008 SHALL provide port force_on, input, 1: override; prevents gating while high.
REQ-009 SHALL provide port clr_cnt, input, 1: synchronous clear of gated_cycles.
REQ-010 SHALL provide port gate_en, output, 1: registered enable to the clock gating cell.
REQ-011 SHALL provide port ready, output, 1: gated domain clocked and stable.
REQ-012 SHALL provide port wake_ack, output, 1: single-cycle pulse when a wake completes.
REQ-013 SHALL provide port gated_cycles, output, CNT_W: saturating count of cycles spent gated.

Function
REQ-014 SHALL implement states RUN, OFF and WAKE, with every output registered and decoded from state.
REQ-015 SHALL define the term idle as (!busy && !wake_req && !force_on), sampled on the rising edge of clk_in.
REQ-016 In RUN, SHALL hold gate_en=1 and ready=1; each idle sample increments idle_cnt, and any non-idle sample clears it to 0.
REQ-017 In RUN, when an idle sample occurs with idle_cnt == IDLE_THRESH-1, SHALL move to OFF on that edge, clearing idle_cnt; gate_en and ready fall on the same edge.
REQ-018 In OFF, SHALL hold gate_en=0 and ready=0; any sample with busy, wake_req or force_on high SHALL move to WAKE on that edge.
REQ-019 On entry to WAKE, SHALL set gate_en=1 and ready=0, and SHALL load wake_cnt=0.
REQ-020 In WAKE, SHALL increment wake_cnt each cycle; when wake_cnt == WAKE_DLY-1, SHALL move to RUN on that edge.
REQ-021 On the WAKE->RUN edge, SHALL set ready=1 and pulse wake_ack=1 for exactly one cycle; wake_ack SHALL be 0 at all other times.
REQ-022 Latency: a wake condition sampled at edge k SHALL produce gate_en=1 after edge k, and ready=1 plus the wake_ack pulse after edge k+WAKE_DLY.
REQ-023 In WAKE, SHALL ignore all inputs; WAKE always completes to RUN, and there is no WAKE->OFF transition.
REQ-024 On RUN entry, SHALL set idle_cnt=0; an idle sample on the first RUN cycle counts as idle cycle 1.
REQ-025 gated_cycles SHALL increment by 1 on each edge where the state is OFF, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-026 clr_cnt=1 SHALL zero gated_cycles on the next edge, with priority over the increment.
REQ-027 When busy, wake_req and force_on are all high together in OFF, SHALL take a single WAKE transition and produce a single wake_ack.
REQ-028 IDLE_THRESH=1 SHALL gate on the first idle sample in RUN.
REQ-029 gate_en SHALL change only on the rising edge of clk_in and SHALL be glitch-free; the downstream cell latches it while clk_in is low.

Reset
REQ-030 rst_n=0 SHALL immediately force state RUN, gate_en=1, ready=1, wake_ack=0, idle_cnt=0, wake_cnt=0 and gated_cycles=0, independent of clk_in.
REQ-031 Reset assertion mid-WAKE or in OFF SHALL abort the current state and SHALL NOT produce a wake_ack pulse.
REQ-032 Deassertion of rst_n SHALL take effect at the first clk_in rising edge after release; the idle count starts from that edge.

Verification
REQ-033 Bench SHALL cover, with IDLE_THRESH=4 and WAKE_DLY=2: reset release, then busy=0 and wake_req=0 for 4 edges -> gate_en falls after the 4th edge, and gated_cycles counts from 1.
REQ-034 Bench SHALL cover idle for 3 edges, busy=1 for 1 edge, then idle for 3 edges -> gate_en stays 1 throughout.
REQ-035 Bench SHALL cover, in OFF, a wake_req pulse at edge k -> gate_en=1 after edge k, ready=1 and a 1-cycle wake_ack after edge k+2.
REQ-036 Bench SHALL cover force_on=1 held for 20 idle cycles -> gate_en stays 1 and gated_cycles stays unchanged.
REQ-037 Bench SHALL cover CNT_W=3 with 10 cycles in OFF -> gated_cycles=7; then clr_cnt=1 for 1 edge -> gated_cycles=0.
REQ-038 Bench SHALL cover rst_n asserted during WAKE -> gate_en=1 and ready=1 immediately, with no wake_ack pulse.
